// File: rtl/uart_fifo_port.sv
// Buffered TramelBlaze UART port: TX/RX FIFOs, autonomous TX drain, RX capture with error flags,
// status/ctrl registers and a maskable interrupt. Optional RX threshold register: UART_RX_THRESH_EN.
module uart_fifo_port #(
    parameter logic [15:0] BASE  = 16'h0000,
    parameter int          DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_out,
    input  logic [15:0] port_id,
    input  logic [15:0] out_port,
    input  logic        write_strobe,
    input  logic        read_strobe,
    input  logic        interrupt_ack,
    output logic [15:0] in_port,
    output logic        interrupt,
    output logic        tx_load,
    output logic [7:0]  tx_data,
    input  logic        TxRdy,
    input  logic        RxRdy,
    input  logic [7:0]  rx_data,
    input  logic        perr,
    input  logic        ferr,
    output logic        rx_clear
);

    localparam int AW      = $clog2(DEPTH);
    localparam int DEPTH_I = DEPTH;
    localparam int ONE_I   = 1;
    localparam int HALF_I  = DEPTH / 2;
    localparam logic [AW:0]   CNT_FULL = DEPTH_I[AW:0];
    localparam logic [AW:0]   CNT_ONE  = ONE_I[AW:0];
    localparam logic [AW-1:0] PTR_ONE  = ONE_I[AW-1:0];
`ifdef UART_RX_THRESH_EN
    localparam logic [3:0]    CTRL_MASK   = 4'b1111;
    localparam logic [AW:0]   THRESH_INIT = HALF_I[AW:0];
`else
    localparam logic [3:0]    CTRL_MASK   = 4'b0111;
`endif

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_BUSY,
        TX_DONE
    } tx_state_t;

    // Address decode: offset wraps, so anything outside BASE..BASE+3 has nonzero upper bits
    logic [15:0] offset;
    logic        sel;
    logic        wr0, wr1, wr2, rd0;
    assign offset = port_id - BASE;
    assign sel    = (offset[15:2] == 14'd0);
    assign wr0    = write_strobe & sel & (offset[1:0] == 2'd0);
    assign wr1    = write_strobe & sel & (offset[1:0] == 2'd1);
    assign wr2    = write_strobe & sel & (offset[1:0] == 2'd2);
    assign rd0    = read_strobe  & sel & (offset[1:0] == 2'd0);

    logic [7:0]    tx_mem [DEPTH];
    logic [9:0]    rx_mem [DEPTH];

    tx_state_t     tx_state_q, tx_state_d;
    logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [AW:0]   tx_count_q, tx_count_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [AW:0]   rx_count_q, rx_count_d;
    logic          rxrdy_q, rxrdy_d;
    logic          rx_clear_q, rx_clear_d;
    logic          rx_ovr_q, rx_ovr_d, tx_ovr_q, tx_ovr_d;
    logic [3:0]    ctrl_q, ctrl_d;
    logic          cond_q, cond_d;
    logic          irq_q, irq_d;
`ifdef UART_RX_THRESH_EN
    logic          wr3;
    logic [AW:0]   thresh_q, thresh_d;
    assign wr3 = write_strobe & sel & (offset[1:0] == 2'd3);
`endif

    logic tx_push, tx_pop, tx_full, tx_empty;
    logic rx_rise, rx_push, rx_pop, rx_full, rx_nempty;
    logic [9:0] rx_head;

    // Full test uses the pre-drain count, so a push racing a drain pop on a full FIFO is dropped
    assign tx_full  = (tx_count_q == CNT_FULL);
    assign tx_push  = wr0 & ~tx_full;
    assign tx_pop   = (tx_state_q == TX_IDLE) && (tx_count_q != '0) && TxRdy;
    assign tx_empty = (tx_count_q == '0) && (tx_state_q == TX_IDLE);

    assign rx_full   = (rx_count_q == CNT_FULL);
    assign rx_nempty = (rx_count_q != '0);
    assign rx_rise   = RxRdy & ~rxrdy_q;
    assign rx_push   = rx_rise & ~rx_full;
    assign rx_pop    = rd0 & rx_nempty;
    assign rx_head   = rx_nempty ? rx_mem[rx_rptr_q] : 10'd0;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_pop) begin
                    tx_data_d  = tx_mem[tx_rptr_q];
                    tx_state_d = TX_LOAD;
                end
            end
            TX_LOAD: tx_state_d = TX_BUSY;
            TX_BUSY: if (!TxRdy) tx_state_d = TX_DONE;
            TX_DONE: if (TxRdy) tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_wptr_d  = tx_push ? tx_wptr_q + PTR_ONE : tx_wptr_q;
        tx_rptr_d  = tx_pop  ? tx_rptr_q + PTR_ONE : tx_rptr_q;
        tx_count_d = tx_count_q;
        if (tx_push && !tx_pop) tx_count_d = tx_count_q + CNT_ONE;
        else if (!tx_push && tx_pop) tx_count_d = tx_count_q - CNT_ONE;

        rx_wptr_d  = rx_push ? rx_wptr_q + PTR_ONE : rx_wptr_q;
        rx_rptr_d  = rx_pop  ? rx_rptr_q + PTR_ONE : rx_rptr_q;
        rx_count_d = rx_count_q;
        if (rx_push && !rx_pop) rx_count_d = rx_count_q + CNT_ONE;
        else if (!rx_push && rx_pop) rx_count_d = rx_count_q - CNT_ONE;

        rxrdy_d    = RxRdy;
        rx_clear_d = rx_rise;
    end

    // Stickies: a new error in the same cycle as its write-1-clear survives
    always_comb begin
        rx_ovr_d = (rx_ovr_q & ~(wr1 & out_port[4])) | (rx_rise & rx_full);
        tx_ovr_d = (tx_ovr_q & ~(wr1 & out_port[5])) | (wr0 & tx_full);
        ctrl_d   = wr2 ? (out_port[3:0] & CTRL_MASK) : ctrl_q;
`ifdef UART_RX_THRESH_EN
        thresh_d = wr3 ? out_port[AW:0] : thresh_q;
`endif
    end

    always_comb begin
        cond_d = (ctrl_q[0] & rx_nempty)
               | (ctrl_q[1] & tx_empty)
               | (ctrl_q[2] & (rx_ovr_q | tx_ovr_q));
`ifdef UART_RX_THRESH_EN
        cond_d = cond_d | (ctrl_q[3] & (rx_count_q >= thresh_q));
`endif
        irq_d = irq_q;
        if (cond_d && !cond_q) irq_d = 1'b1;
        else if (interrupt_ack) irq_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst_out) begin
        if (rst_out) begin
            tx_state_q <= TX_IDLE;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_count_q <= '0;
            tx_data_q  <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_count_q <= '0;
            rxrdy_q    <= 1'b0;
            rx_clear_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            tx_ovr_q   <= 1'b0;
            ctrl_q     <= '0;
            cond_q     <= 1'b0;
            irq_q      <= 1'b0;
`ifdef UART_RX_THRESH_EN
            thresh_q   <= THRESH_INIT;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_count_q <= tx_count_d;
            tx_data_q  <= tx_data_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_count_q <= rx_count_d;
            rxrdy_q    <= rxrdy_d;
            rx_clear_q <= rx_clear_d;
            rx_ovr_q   <= rx_ovr_d;
            tx_ovr_q   <= tx_ovr_d;
            ctrl_q     <= ctrl_d;
            cond_q     <= cond_d;
            irq_q      <= irq_d;
`ifdef UART_RX_THRESH_EN
            thresh_q   <= thresh_d;
`endif
        end
    end

    // Storage arrays carry no reset; validity is tracked by the pointers and counts
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_q] <= out_port[7:0];
        if (rx_push) rx_mem[rx_wptr_q] <= {ferr, perr, rx_data};
    end

    logic [8:0]  rx_count_ext;
    logic [15:0] status;
    logic [15:0] thresh_rd;
    logic        unused_bits;
    assign rx_count_ext = 9'(rx_count_q);
    assign status = {rx_count_ext[7:0], rx_full, tx_empty, tx_ovr_q, rx_ovr_q,
                     rx_head[9], rx_head[8], ~tx_full, rx_nempty};
    assign unused_bits = ^{out_port[15:8], rx_count_ext[8]};

    always_comb begin
        thresh_rd = '0;
`ifdef UART_RX_THRESH_EN
        thresh_rd[AW:0] = thresh_q;
`endif
        in_port = '0;
        if (sel) begin
            case (offset[1:0])
                2'd0:    in_port = {8'h00, rx_head[7:0]};
                2'd1:    in_port = status;
                2'd2:    in_port = {12'h000, ctrl_q};
                default: in_port = thresh_rd;
            endcase
        end
    end

    assign interrupt = irq_q;
    assign tx_load   = (tx_state_q == TX_LOAD);
    assign tx_data   = tx_data_q;
    assign rx_clear  = rx_clear_q;

endmodule
